// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with HI/LO result registers.
//   Runs MULTU/MULT (shift-add) and DIVU/DIV (restoring shift-subtract) over
//   WIDTH cycles. The unit works on operand magnitudes, and the sign fix-up is
//   folded into the final result write.
// Ports:
//   clock, reset      - clock; synchronous active-high reset
//   start, op, a, b   - issue request (sampled only when idle), op select
//                       (00 MULTU, 01 MULT, 10 DIVU, 11 DIV), operands rs/rt
//   hi_write/lo_write - MTHI/MTLO, write wdata when idle and not starting
//   busy              - operation in flight
//   done              - one-cycle pulse when an operation updates HI/LO
//   hi, lo            - result registers
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_write,
  input  logic             lo_write,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]      cnt;
  logic [1:0]         op_q;     // op[0]: signed, op[1]: divide
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   a_q;      // raw dividend, returned as HI on divide-by-zero
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic               last;

  // Operand magnitudes at issue time
  logic             neg_a_in, neg_b_in;
  logic [WIDTH-1:0] mag_a_in, mag_b_in;

  assign neg_a_in = op[0] & a[WIDTH-1];
  assign neg_b_in = op[0] & b[WIDTH-1];
  assign mag_a_in = neg_a_in ? -a : a;
  assign mag_b_in = neg_b_in ? -b : b;

  assign busy = (state == RUN);
  assign last = (cnt == CW'(WIDTH-1));

  // FSM
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One iteration. Both operations keep the working pair in acc:
  //   multiply: acc = {partial product, remaining multiplier bits}
  //   divide:   acc = {partial remainder, dividend bits / quotient bits}
  logic [WIDTH:0] mul_sum, div_t, div_d;
  logic           div_ge;

  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag_b : {WIDTH{1'b0}})};
    div_t   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge  = (div_t >= {1'b0, mag_b});
    div_d   = div_t - {1'b0, mag_b};
    if (op_q[1])
      acc_nxt = {(div_ge ? div_d[WIDTH-1:0] : div_t[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
    else
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
  end

  // Sign fix-up on the final iteration's value
  logic               neg_res;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;

  always_comb begin
    neg_res = op_q[0] & (sign_a ^ sign_b);
    prod    = neg_res ? -acc_nxt : acc_nxt;
    quo     = acc_nxt[WIDTH-1:0];
    rem     = acc_nxt[2*WIDTH-1:WIDTH];
    res_hi  = prod[2*WIDTH-1:WIDTH];
    res_lo  = prod[WIDTH-1:0];
    if (op_q[1]) begin
      if (mag_b == '0) begin
        res_hi = a_q;
        res_lo = '1;
      end else begin
        res_hi = (op_q[0] & sign_a) ? -rem : rem;
        res_lo = neg_res ? -quo : quo;
      end
    end
  end

  // Datapath and HI/LO
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt    <= '0;
      op_q   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      a_q    <= '0;
      mag_b  <= '0;
      acc    <= '0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          op_q   <= op;
          sign_a <= neg_a_in;
          sign_b <= neg_b_in;
          a_q    <= a;
          mag_b  <= mag_b_in;
          acc    <= {{WIDTH{1'b0}}, mag_a_in};
          cnt    <= '0;
        end else begin
          // start wins over MTHI/MTLO on the same edge
          if (hi_write) hi <= wdata;
          if (lo_write) lo <= wdata;
        end
      end else begin
        acc <= acc_nxt;
        cnt <= cnt + 1'b1;
        if (last) begin
          hi   <= res_hi;
          lo   <= res_lo;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: hand-computed HI/LO results, timing of
// busy/done, ignored start/MTHI while busy, reset abort, and HI/LO writes.
module tb_muldiv_unit;

  logic        clock, reset, start, hi_write, lo_write;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_chk  = 0;
  int n_pass = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_write(hi_write), .lo_write(lo_write), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one op and follow it to completion. A stray start with a different
  // op is raised mid-run and must be ignored.
  task automatic run_op(input logic [1:0] o, input logic [31:0] oa, input logic [31:0] ob,
                        input logic [31:0] eh, input logic [31:0] el, input string tag);
    logic [31:0] h0, l0;
    int bad;
    h0 = hi; l0 = lo;
    op = o; a = oa; b = ob; start = 1'b1;
    tick();                                   // E0
    start = 1'b0; hi_write = 1'b0; lo_write = 1'b0;
    a = $urandom; b = $urandom;               // operands must already be latched
    check({tag, ":busy_e0"}, 64'(busy), 64'd1);
    bad = 0;
    for (int i = 1; i < 32; i++) begin
      if (i == 5) begin start = 1'b1; op = ~o; end
      if (i == 6) start = 1'b0;
      tick();                                 // E1..E31
      if (!busy || done || hi !== h0 || lo !== l0) bad++;
    end
    check({tag, ":run"}, 64'(bad), 64'd0);
    tick();                                   // E32
    check({tag, ":done"}, 64'({done, busy}), 64'b10);
    check({tag, ":hilo"}, {hi, lo}, {eh, el});
    tick();                                   // E33
    check({tag, ":done_clr"}, 64'({done, busy}), 64'b00);
  endtask

  initial begin
    int bad;
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_write = 1'b0; lo_write = 1'b0; wdata = '0;
    tick(); tick();
    check("reset", {30'd0, busy, done, hi}, 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    tick();

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    run_op(2'b01, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg");
    run_op(2'b01, 32'hFFFF_FFFB, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0014, "mult_negneg");
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_nega");
    run_op(2'b11, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_negb");
    run_op(2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        "divu");
    run_op(2'b10, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, "divu_zero");
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf");

    // MULTU 3*5 with a DIVU start at cycle 10 and MTHI at cycle 12, both ignored
    op = 2'b00; a = 32'd3; b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    bad = 0;
    for (int i = 1; i < 32; i++) begin
      if (i == 10) begin start = 1'b1; op = 2'b10; a = 32'd9; b = 32'd3; end
      if (i == 11) start = 1'b0;
      if (i == 12) begin hi_write = 1'b1; wdata = 32'h0000_DEAD; end
      if (i == 13) hi_write = 1'b0;
      tick();
      if (!busy || done || hi !== 32'h0 || lo !== 32'h8000_0000) bad++;
    end
    check("busy_ign:run", 64'(bad), 64'd0);
    tick();
    check("busy_ign:done", 64'({done, busy}), 64'b10);
    check("busy_ign:hilo", {hi, lo}, {32'd0, 32'd15});
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) bad++;
    end
    check("busy_ign:no_queue", 64'(bad), 64'd0);

    // Reset aborts an in-flight MULT
    op = 2'b01; a = 32'hFFFF_FFFD; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 20; i++) tick();
    reset = 1'b1;
    tick();
    check("abort", {30'd0, busy, done, hi}, 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done || busy || hi !== 32'h0 || lo !== 32'h0) bad++;
    end
    check("abort:quiet", 64'(bad), 64'd0);

    // MTHI + MTLO together, then MTLO alone
    hi_write = 1'b1; lo_write = 1'b1; wdata = 32'hA5A5_A5A5;
    tick();
    hi_write = 1'b0; lo_write = 1'b0;
    check("mthilo", {hi, lo}, {32'hA5A5_A5A5, 32'hA5A5_A5A5});
    lo_write = 1'b1; wdata = 32'h0000_0001;
    tick();
    lo_write = 1'b0;
    check("mtlo", {hi, lo}, {32'hA5A5_A5A5, 32'h0000_0001});

    // start and MTHI on the same edge: start wins, HI untouched until result
    hi_write = 1'b1; wdata = 32'h0000_FFFF;
    run_op(2'b00, 32'd2, 32'd3, 32'd0, 32'd6, "start_wins");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit directly downstream of the general-purpose register file.
- Consumes the two register read operands (rs → a, rt → b) and executes MULT, MULTU, DIV and DIVU iteratively over 32 cycles.
- Holds the HI/LO result registers and supports direct HI/LO writes for MTHI/MTLO.
- Asserts busy so the control path stalls MFHI/MFLO and new mul/div issue until the result is ready.

Parameters:
- WIDTH, 32, operand and HI/LO width. Iteration count equals WIDTH.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  issue request; sampled only when busy=0.
- op  input  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- a  input  WIDTH  operand from register file read port 1 (rs).
- b  input  WIDTH  operand from register file read port 2 (rt).
- hi_write  input  1  MTHI: write wdata into HI.
- lo_write  input  1  MTLO: write wdata into LO.
- wdata  input  WIDTH  data for hi_write/lo_write.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when HI/LO are updated by an operation.
- hi  output  WIDTH  HI register (multiply upper half / remainder).
- lo  output  WIDTH  LO register (multiply lower half / quotient).

Behaviour:
- Reset (reset=1 at a clock edge):
  - busy=0, done=0, hi=0, lo=0, iteration counter=0.
  - Any in-flight operation is abandoned with no HI/LO update.
  - Reset has priority over every other input.
- States: IDLE, RUN.
- IDLE:
  - start=1 at edge E0 latches a, b and op, goes to RUN, busy=1, counter=0.
  - Signed ops latch operand magnitudes plus the sign bits of a and b.
- RUN:
  - One iteration per edge.
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract.
  - Edges E1..E32 perform iterations 0..31.
  - At E32: HI/LO are written, busy→0, done→1, return to IDLE.
  - done returns to 0 at E33 unless a new op completes there, which is impossible.
  - Result is visible on hi/lo exactly 32 cycles after the start edge.
- Sign fix-up (applied in the E32 write):
  - MULT: negate the 64-bit product if sign_a^sign_b.
  - DIV: negate the quotient if sign_a^sign_b; the remainder takes sign_a.
  - Unsigned ops: no fix-up.
- Divide by zero (b=0, DIV or DIVU): lo=all ones, hi=a (original, unsigned-magnitude-free value). Still takes 32 cycles with done pulse.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0, with no trap.
- start while busy=1: ignored; no queuing; the in-flight op is unaffected.
- Same-edge a/b changes after E0 have no effect; operands are latched.
- hi_write/lo_write:
  - Accepted only in IDLE with start=0, and take effect at that edge.
  - Ignored while busy=1 and ignored when start=1 on the same edge (start wins).
  - hi_write and lo_write together update both registers from wdata.
- hi/lo hold their values at all times except at reset, an accepted HI/LO write, or the E32 result write.
- Intermediate accumulator contents are never exposed on hi/lo.
- All arithmetic is modulo 2^WIDTH per half. The product is a full 2*WIDTH bits with no truncation.

Test Plan:
- Reset, then MULTU a=0xFFFFFFFF b=0xFFFFFFFF → busy high for 32 cycles; at E32 hi=0xFFFFFFFE, lo=0x00000001, done pulses for exactly one cycle.
- MULT a=0xFFFFFFFD (-3) b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV a=0xFFFFFFF9 (-7) b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100 b=7 → lo=14, hi=2. DIVU a=0x12345678 b=0 → lo=0xFFFFFFFF, hi=0x12345678. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Start MULTU 3*5; reassert start with DIVU 9/3 at cycle 10 and pulse hi_write (wdata=0xDEAD) at cycle 12 → both ignored; at E32 hi=0, lo=15, and no second done pulse follows.
- Start MULT, assert reset at cycle 20 → next edge busy=0, hi=lo=0, no done. Then hi_write=1 lo_write=1 wdata=0xA5A5A5A5 in IDLE → hi=lo=0xA5A5A5A5 after one edge.
